// File: rtl/mux_gate_pkg.sv
// Shared op-code constants and the op_sel type for the mux-based gate bank.
package mux_gate_pkg;

    typedef logic [1:0] op_sel_t;

    localparam op_sel_t OP_AND  = 2'b00;
    localparam op_sel_t OP_NAND = 2'b01;
    localparam op_sel_t OP_NOR  = 2'b10;
    localparam op_sel_t OP_RSVD = 2'b11;

endpackage

// File: rtl/mux_gate_bank_mux2.sv
// Bitwise 2:1 multiplexer primitive; every gate in the bank is built from this.
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o[i] = sel[i] ? d1[i] : d0[i];
    end

endmodule

// File: rtl/mux_gate_bank.sv
// Registered AND/NAND/NOR bank built purely from mux2 cells, plus an
// op-selected result y. One-cycle latency, accepts a new input every cycle.
module mux_gate_bank
    import mux_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_sel_t          op_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] x_and,
    output logic [WIDTH-1:0] x_nand,
    output logic [WIDTH-1:0] x_nor,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] w_ones;
    logic [WIDTH-1:0] w_zeros;
    logic [WIDTH-1:0] w_nb;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] w_y_lo;
    logic [WIDTH-1:0] w_y_hi;
    logic [WIDTH-1:0] w_y;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_x_and;
    logic [WIDTH-1:0] r_x_nand;
    logic [WIDTH-1:0] r_x_nor;
    logic [WIDTH-1:0] r_y;

    assign w_ones  = '1;
    assign w_zeros = '0;

    mux2 #(.WIDTH(WIDTH)) u_inv  (.sel(b), .d0(w_ones),  .d1(w_zeros), .o(w_nb));
    mux2 #(.WIDTH(WIDTH)) u_and  (.sel(a), .d0(w_zeros), .d1(b),       .o(w_and));
    mux2 #(.WIDTH(WIDTH)) u_nand (.sel(a), .d0(w_ones),  .d1(w_nb),    .o(w_nand));
    mux2 #(.WIDTH(WIDTH)) u_nor  (.sel(a), .d0(w_nb),    .d1(w_zeros), .o(w_nor));

    // Two-level select tree: op_sel[0] picks within each pair, op_sel[1] picks the pair.
    mux2 #(.WIDTH(WIDTH)) u_sel_lo (
        .sel({WIDTH{op_sel[0]}}), .d0(w_and), .d1(w_nand), .o(w_y_lo)
    );
    mux2 #(.WIDTH(WIDTH)) u_sel_hi (
        .sel({WIDTH{op_sel[0]}}), .d0(w_nor), .d1(w_zeros), .o(w_y_hi)
    );
    mux2 #(.WIDTH(WIDTH)) u_sel_top (
        .sel({WIDTH{op_sel[1]}}), .d0(w_y_lo), .d1(w_y_hi), .o(w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_x_and     <= '0;
            r_x_nand    <= '0;
            r_x_nor     <= '0;
            r_y         <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_x_and  <= w_and;
                r_x_nand <= w_nand;
                r_x_nor  <= w_nor;
                r_y      <= w_y;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign x_and     = r_x_and;
    assign x_nand    = r_x_nand;
    assign x_nor     = r_x_nor;
    assign y         = r_y;

endmodule

// File: tb/tb_mux_gate_bank.sv
// Scoreboard bench for mux_gate_bank: one WIDTH=8 and one WIDTH=1 instance share stimulus.
module tb_mux_gate_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op_sel = 2'b00;

    logic       ov8, ov1;
    logic [7:0] xa8, xn8, xr8, y8;
    logic [0:0] xa1, xn1, xr1, y1;

    int tests = 0;
    int fails = 0;

    // {valid, and[7:0], nand[7:0], nor[7:0], y[7:0]}
    logic [32:0] sb[$];
    logic [32:0] last = '0;

    always #5 clk = ~clk;

    mux_gate_bank #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op_sel(op_sel),
        .out_valid(ov8), .x_and(xa8), .x_nand(xn8), .x_nor(xr8), .y(y8)
    );

    mux_gate_bank #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]), .op_sel(op_sel),
        .out_valid(ov1), .x_and(xa1), .x_nand(xn1), .x_nor(xr1), .y(y1)
    );

    function automatic logic [32:0] model(input logic [7:0] av, input logic [7:0] bv,
                                          input logic [1:0] op);
        logic [7:0] m_and, m_nand, m_nor, m_y;
        m_and  = av & bv;
        m_nand = ~(av & bv);
        m_nor  = ~(av | bv);
        case (op)
            2'b00:   m_y = m_and;
            2'b01:   m_y = m_nand;
            2'b10:   m_y = m_nor;
            default: m_y = 8'h00;
        endcase
        return {1'b1, m_and, m_nand, m_nor, m_y};
    endfunction

    function automatic logic [32:0] obs8();
        return {ov8, xa8, xn8, xr8, y8};
    endfunction

    function automatic logic [4:0] obs1();
        return {ov1, xa1, xn1, xr1, y1};
    endfunction

    function automatic logic [4:0] lo(input logic [32:0] e);
        return {e[32], e[24], e[16], e[8], e[0]};
    endfunction

    // Drives one cycle of stimulus, records the expectation, returns #1 after the edge.
    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                         input logic [1:0] op);
        in_valid = v;
        a        = av;
        b        = bv;
        op_sel   = op;
        if (v && rst_n) sb.push_back(model(av, bv, op));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] e;
        rst_n = 1'b0;
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op_sel = 2'b00;
        #3;
        tests++;
        if (obs8() !== 33'h0 || obs1() !== 5'h0) begin
            fails++;
            $display("FAIL reset_async obs8=%h obs1=%b expected 0", obs8(), obs1());
        end
        @(posedge clk); #1;
        tests++;
        if (obs8() !== 33'h0) begin
            fails++;
            $display("FAIL reset_clocked obs8=%h expected 0", obs8());
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'hFF, 8'hFF, 2'b00);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL reset_first scoreboard empty");
        end else begin
            e = sb.pop_front();
            last = e;
            if (obs8() !== e || obs1() !== 5'b11001) begin
                fails++;
                $display("FAIL reset_first obs8=%h exp=%h obs1=%b exp=11001", obs8(), e, obs1());
            end
        end
    endtask

    task automatic test_truth_table();
        logic [32:0] e;
        logic [3:0]  t_and  = 4'b1000;
        logic [3:0]  t_nand = 4'b0111;
        logic [3:0]  t_nor  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {7'h00, i[1]}, {7'h00, i[0]}, 2'b00);
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL truth_table[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                last = e;
                if (obs8() !== e ||
                    obs1() !== {1'b1, t_and[i], t_nand[i], t_nor[i], t_and[i]}) begin
                    fails++;
                    $display("FAIL truth_table[%0d] obs8=%h exp=%h obs1=%b", i, obs8(), e, obs1());
                end
            end
        end
    endtask

    task automatic test_op_sel();
        logic [32:0] e;
        logic [3:0]  y_zero = 4'b0110;  // indexed by op_sel, operands 0/0
        logic [3:0]  y_one  = 4'b0001;  // operands all ones
        for (int k = 0; k < 8; k++) begin
            logic [7:0] opv;
            logic       ey;
            opv = (k < 4) ? 8'h00 : 8'hFF;
            ey  = (k < 4) ? y_zero[k % 4] : y_one[k % 4];
            drive(1'b1, opv, opv, 2'(k % 4));
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL op_sel[%0d] scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                last = e;
                if (obs8() !== e || y1 !== ey || y8 !== {8{ey}}) begin
                    fails++;
                    $display("FAIL op_sel[%0d] y8=%h y1=%b exp_y=%b obs8=%h exp=%h",
                             k, y8, y1, ey, obs8(), e);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [32:0] e;
        drive(1'b1, 8'h01, 8'h00, 2'b00);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL hold_capture scoreboard empty");
        end else begin
            e = sb.pop_front();
            last = e;
            if (obs8() !== e || obs1() !== 5'b10100) begin
                fails++;
                $display("FAIL hold_capture obs8=%h exp=%h obs1=%b exp=10100", obs8(), e, obs1());
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'($urandom), 8'($urandom), 2'($urandom));
            tests++;
            if (obs8() !== {1'b0, last[31:0]} || obs1() !== 5'b00100) begin
                fails++;
                $display("FAIL hold[%0d] obs8=%h exp=%h obs1=%b exp=00100",
                         k, obs8(), {1'b0, last[31:0]}, obs1());
            end
        end
    endtask

    task automatic test_width8();
        logic [32:0] e;
        drive(1'b1, 8'hF0, 8'hCC, 2'b10);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL width8 scoreboard empty");
        end else begin
            e = sb.pop_front();
            last = e;
            if (obs8() !== e || xa8 !== 8'hC0 || xn8 !== 8'h3F || xr8 !== 8'h03 || y8 !== 8'h03) begin
                fails++;
                $display("FAIL width8 and=%h nand=%h nor=%h y=%h exp C0 3F 03 03",
                         xa8, xn8, xr8, y8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        for (int k = 0; k < 24; k++) begin
            logic v;
            v = (k % 7 != 6);
            drive(v, 8'($urandom), 8'($urandom), 2'($urandom));
            tests++;
            if (!v) begin
                if (obs8() !== {1'b0, last[31:0]} || obs1() !== lo({1'b0, last[31:0]})) begin
                    fails++;
                    $display("FAIL b2b_gap[%0d] obs8=%h exp=%h", k, obs8(), {1'b0, last[31:0]});
                end
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL b2b[%0d] scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                last = e;
                if (obs8() !== e || obs1() !== lo(e)) begin
                    fails++;
                    $display("FAIL b2b[%0d] obs8=%h exp=%h obs1=%b exp=%b",
                             k, obs8(), e, obs1(), lo(e));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [32:0] e;
        drive(1'b1, 8'hA5, 8'h0F, 2'b01);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            last = e;
        end
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op_sel = 2'b00;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs8() !== 33'h0 || obs1() !== 5'h0) begin
            fails++;
            $display("FAIL midreset_async obs8=%h obs1=%b expected 0", obs8(), obs1());
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        last = '0;
        drive(1'b0, 8'h12, 8'h34, 2'b00);
        tests++;
        if (obs8() !== 33'h0 || obs1() !== 5'h0 || sb.size() != 0) begin
            fails++;
            $display("FAIL midreset_discard obs8=%h obs1=%b sb=%0d expected 0",
                     obs8(), obs1(), sb.size());
        end
        drive(1'b1, 8'h3C, 8'h5A, 2'b10);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL midreset_resume scoreboard empty");
        end else begin
            e = sb.pop_front();
            last = e;
            if (obs8() !== e || obs1() !== lo(e)) begin
                fails++;
                $display("FAIL midreset_resume obs8=%h exp=%h", obs8(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_op_sel();
        test_hold();
        test_width8();
        test_back_to_back();
        test_reset_midstream();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
